// File: rtl/column_buffer_pkg.sv
// Shared definitions for the CPU/GPU column buffer: geometry, field and
// swap-state encodings, and the column range check used on every port.
package column_buffer_pkg;

    localparam int          COLUMNS      = 320;
    localparam int          IDX_W        = 9;
    localparam logic [15:0] FAR_DISTANCE = 16'hFFFF;

    // Low bit of the CPU address picks which half of a column word is accessed.
    typedef enum logic {
        FIELD_DIST = 1'b0,
        FIELD_TEX  = 1'b1
    } field_e;

    typedef enum logic {
        SWAP_IDLE    = 1'b0,
        SWAP_PENDING = 1'b1
    } swap_state_e;

    // Full-width unsigned compare, so no index above 319 can alias to a real column.
    function automatic logic col_in_range(input logic [IDX_W-1:0] col);
        return col < IDX_W'(COLUMNS);
    endfunction

endpackage

// File: rtl/column_ram.sv
// One bank of column storage: COLUMNS x 32 bits.
// Lane 0 holds distance and lane 1 holds texture.
// It has one write port with per-half enables and one registered read port,
// a shape that maps directly onto a block RAM.
module column_ram #(
    parameter int DEPTH  = 320,
    parameter int ADDR_W = 9
) (
    input  logic              clk,
    input  logic [1:0]        wbe,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    logic [31:0] mem [DEPTH];

    // Half-word writes and a registered read. Reading and writing the same address
    // in one cycle returns the old contents.
    // NOTE: the array and its read register have no reset. A reset branch here
    // would stop the tools from mapping the bank onto block RAM.
    always_ff @(posedge clk) begin
        if (wbe[0]) mem[waddr][15:0]  <= wdata;
        if (wbe[1]) mem[waddr][31:16] <= wdata;
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/column_buffer.sv
// Double-buffered column store between the CPU (writes the back bank) and the
// raycast GPU (reads the front bank). A requested swap is held until the next
// falling edge of the active-low v_sync, so each displayed frame comes from one
// CPU frame.
module column_buffer
    import column_buffer_pkg::*;
(
    input  logic             clk,
    input  logic             clr,
    input  logic             cpu_we,
    input  logic [IDX_W:0]   cpu_addr,
    input  logic [15:0]      cpu_wdata,
    output logic [15:0]      cpu_rdata,
    input  logic             swap_req,
    output logic             swap_pending,
    output logic             frame_swapped,
    input  logic             v_sync,
    input  logic [IDX_W-1:0] reading_index,
    output logic [15:0]      distance,
    output logic [15:0]      texture
);

    logic [IDX_W-1:0] cpu_col;
    field_e           cpu_field;
    logic             cpu_ok;
    logic             gpu_ok;
    logic [IDX_W-1:0] cpu_raddr;
    logic [IDX_W-1:0] gpu_raddr;
    logic [1:0]       cpu_lanes;

    logic             front_sel;
    logic             v_sync_q;
    logic             v_fall;
    logic             do_swap;
    swap_state_e      state;
    swap_state_e      next_state;

    logic [IDX_W-1:0] raddr0;
    logic [IDX_W-1:0] raddr1;
    logic [1:0]       wbe0;
    logic [1:0]       wbe1;
    logic [31:0]      rdata0;
    logic [31:0]      rdata1;

    logic             out_valid;
    logic             front_q;
    logic             gpu_oor_q;
    logic             cpu_oor_q;
    field_e           cpu_field_q;
    logic [31:0]      front_word;
    logic [31:0]      back_word;

    assign cpu_col   = cpu_addr[IDX_W:1];
    assign cpu_field = field_e'(cpu_addr[0]);
    assign cpu_ok    = col_in_range(cpu_col);
    assign gpu_ok    = col_in_range(reading_index);

    // Out-of-range indices are parked at column 0. Their data is replaced at the output.
    assign cpu_raddr = cpu_ok ? cpu_col : '0;
    assign gpu_raddr = gpu_ok ? reading_index : '0;
    assign cpu_lanes = (cpu_field == FIELD_TEX) ? 2'b10 : 2'b01;

    // The front bank serves the GPU. The back bank serves CPU writes and readback.
    assign raddr0 = front_sel ? cpu_raddr : gpu_raddr;
    assign raddr1 = front_sel ? gpu_raddr : cpu_raddr;
    assign wbe0   = (cpu_we && cpu_ok &&  front_sel) ? cpu_lanes : 2'b00;
    assign wbe1   = (cpu_we && cpu_ok && !front_sel) ? cpu_lanes : 2'b00;

    column_ram #(.DEPTH(COLUMNS), .ADDR_W(IDX_W)) bank0 (
        .clk   (clk),
        .wbe   (wbe0),
        .waddr (cpu_raddr),
        .wdata (cpu_wdata),
        .raddr (raddr0),
        .rdata (rdata0)
    );

    column_ram #(.DEPTH(COLUMNS), .ADDR_W(IDX_W)) bank1 (
        .clk   (clk),
        .wbe   (wbe1),
        .waddr (cpu_raddr),
        .wdata (cpu_wdata),
        .raddr (raddr1),
        .rdata (rdata1)
    );

    // A fall is seen in the first cycle that v_sync is sampled low against its
    // registered copy. The bank toggle takes effect at that same clock edge.
    assign v_fall = v_sync_q && !v_sync;

    // Swap state register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= SWAP_IDLE;
        else     state <= next_state;
    end

    // Next-state logic. While a swap is pending, more requests are ignored.
    // A request arriving with a v_sync fall waits for the next frame.
    // NOTE: every output of this block gets a default before the case. Without
    // it, a path that does not assign the output infers a latch.
    always_comb begin
        next_state = state;
        do_swap    = 1'b0;
        case (state)
            SWAP_IDLE: begin
                if (swap_req) next_state = SWAP_PENDING;
            end
            SWAP_PENDING: begin
                if (v_fall) begin
                    next_state = SWAP_IDLE;
                    do_swap    = 1'b1;
                end
            end
            default: next_state = SWAP_IDLE;
        endcase
    end

    assign swap_pending = (state == SWAP_PENDING);

    // Bank select, swap pulse and v_sync edge register.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            front_sel     <= 1'b0;
            frame_swapped <= 1'b0;
            v_sync_q      <= 1'b1;
        end else begin
            front_sel     <= front_sel ^ do_swap;
            frame_swapped <= do_swap;
            v_sync_q      <= v_sync;
        end
    end

    // Side information registered with each RAM read. It records which bank was
    // read, whether each index was in range, and whether a read has happened
    // since reset.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_valid   <= 1'b0;
            front_q     <= 1'b0;
            gpu_oor_q   <= 1'b0;
            cpu_oor_q   <= 1'b0;
            cpu_field_q <= FIELD_DIST;
        end else begin
            out_valid   <= 1'b1;
            front_q     <= front_sel;
            gpu_oor_q   <= !gpu_ok;
            cpu_oor_q   <= !cpu_ok;
            cpu_field_q <= cpu_field;
        end
    end

    assign front_word = front_q ? rdata1 : rdata0;
    assign back_word  = front_q ? rdata0 : rdata1;

    assign distance  = !out_valid ? 16'h0000 :
                       gpu_oor_q  ? FAR_DISTANCE : front_word[15:0];
    assign texture   = (!out_valid || gpu_oor_q) ? 16'h0000 : front_word[31:16];
    assign cpu_rdata = (!out_valid || cpu_oor_q) ? 16'h0000 :
                       (cpu_field_q == FIELD_TEX) ? back_word[31:16] : back_word[15:0];

endmodule

// File: tb/tb_column_buffer.sv
// Self-checking bench for column_buffer.
// A reference model holds two banks as plain arrays, plus the front index and
// the pending-swap flag, and it applies the block's rules at transaction level.
module tb_column_buffer;

    localparam int NCOL = 320;

    logic        clk = 1'b0;
    logic        clr;
    logic        cpu_we;
    logic [9:0]  cpu_addr;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        swap_req;
    logic        swap_pending;
    logic        frame_swapped;
    logic        v_sync;
    logic [8:0]  reading_index;
    logic [15:0] distance;
    logic [15:0] texture;

    int checks = 0;
    int errors = 0;

    // Reference model.
    logic [15:0] m_dist [2][NCOL];
    logic [15:0] m_tex  [2][NCOL];
    int          m_front;
    bit          m_pending;

    column_buffer dut (
        .clk           (clk),
        .clr           (clr),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_rdata     (cpu_rdata),
        .swap_req      (swap_req),
        .swap_pending  (swap_pending),
        .frame_swapped (frame_swapped),
        .v_sync        (v_sync),
        .reading_index (reading_index),
        .distance      (distance),
        .texture       (texture)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] exp_dist(input int idx);
        return (idx < NCOL) ? m_dist[m_front][idx] : 16'hFFFF;
    endfunction

    function automatic logic [15:0] exp_tex(input int idx);
        return (idx < NCOL) ? m_tex[m_front][idx] : 16'h0000;
    endfunction

    function automatic logic [15:0] exp_back(input int col, input bit field);
        if (col >= NCOL) return 16'h0000;
        return field ? m_tex[1-m_front][col] : m_dist[1-m_front][col];
    endfunction

    task automatic cpu_write(input int col, input bit field, input logic [15:0] data);
        logic [8:0] c;
        c         = col[8:0];
        cpu_addr  = {c, field};
        cpu_wdata = data;
        cpu_we    = 1'b1;
        step();
        cpu_we    = 1'b0;
        if (col < NCOL) begin
            if (field) m_tex[1-m_front][col]  = data;
            else       m_dist[1-m_front][col] = data;
        end
    endtask

    task automatic cpu_read(input int col, input bit field);
        logic [8:0] c;
        c        = col[8:0];
        cpu_addr = {c, field};
        step();
    endtask

    task automatic gpu_read(input int idx);
        reading_index = idx[8:0];
        step();
    endtask

    task automatic request_swap();
        swap_req = 1'b1;
        step();
        swap_req = 1'b0;
        m_pending = 1'b1;
    endtask

    // Hold v_sync low for a few cycles and count the swap pulses, then return it high.
    task automatic vsync_fall(output int pulses);
        pulses = 0;
        v_sync = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            if (frame_swapped === 1'b1) pulses++;
        end
        if (m_pending) begin
            m_front   = 1 - m_front;
            m_pending = 1'b0;
        end
        v_sync = 1'b1;
        step();
        step();
    endtask

    task automatic test_reset();
        clr = 1'b1;
        cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        swap_req = 1'b0; v_sync = 1'b1; reading_index = 9'd320;
        m_front = 0; m_pending = 1'b0;
        #3;
        checks++;
        if (distance !== 16'h0 || texture !== 16'h0 || cpu_rdata !== 16'h0) begin
            errors++;
            $display("FAIL reset_outputs got d=%h t=%h r=%h expected 0000", distance, texture, cpu_rdata);
        end
        checks++;
        if (swap_pending !== 1'b0 || frame_swapped !== 1'b0) begin
            errors++;
            $display("FAIL reset_swap got pend=%b fs=%b expected 0 0", swap_pending, frame_swapped);
        end
        step(); step();
        clr = 1'b0;
        for (int i = 0; i < 10; i++) begin
            int idx;
            idx = (i == 0) ? 320 : int'($urandom_range(511, 320));
            gpu_read(idx);
            checks++;
            if (distance !== 16'hFFFF || texture !== 16'h0000) begin
                errors++;
                $display("FAIL reset_oor_read idx=%0d got d=%h t=%h expected ffff 0000", idx, distance, texture);
            end
        end
        checks++;
        if (swap_pending !== 1'b0 || frame_swapped !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_swap got pend=%b fs=%b expected 0 0", swap_pending, frame_swapped);
        end
    endtask

    task automatic test_fill_and_read();
        int pulses;
        for (int b = 0; b < 2; b++) begin
            for (int c = 0; c < NCOL; c++) begin
                cpu_write(c, 1'b0, 16'($urandom));
                cpu_write(c, 1'b1, 16'($urandom));
            end
            request_swap();
            vsync_fall(pulses);
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL fill_swap bank=%0d got pulses=%0d expected 1", b, pulses);
            end
        end
        for (int i = 0; i < 40; i++) begin
            int idx;
            idx = (i % 5 == 4) ? int'($urandom_range(511, 320)) : int'($urandom_range(NCOL - 1, 0));
            gpu_read(idx);
            checks++;
            if (distance !== exp_dist(idx) || texture !== exp_tex(idx)) begin
                errors++;
                $display("FAIL gpu_read idx=%0d got d=%h t=%h expected d=%h t=%h",
                         idx, distance, texture, exp_dist(idx), exp_tex(idx));
            end
        end
        for (int i = 0; i < 20; i++) begin
            int col;
            bit f;
            col = (i % 4 == 3) ? int'($urandom_range(511, 320)) : int'($urandom_range(NCOL - 1, 0));
            f   = 1'($urandom);
            cpu_read(col, f);
            checks++;
            if (cpu_rdata !== exp_back(col, f)) begin
                errors++;
                $display("FAIL cpu_readback col=%0d f=%0d got %h expected %h", col, f, cpu_rdata, exp_back(col, f));
            end
        end
    endtask

    task automatic test_basic_swap();
        int pulses;
        cpu_write(5, 1'b0, 16'h0123);
        cpu_write(5, 1'b1, 16'h002A);
        request_swap();
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL basic_pending got %b expected 1", swap_pending);
        end
        vsync_fall(pulses);
        checks++;
        if (pulses != 1 || swap_pending !== 1'b0) begin
            errors++;
            $display("FAIL basic_swap got pulses=%0d pend=%b expected 1 0", pulses, swap_pending);
        end
        gpu_read(5);
        checks++;
        if (distance !== 16'h0123 || texture !== 16'h002A) begin
            errors++;
            $display("FAIL basic_col5 got d=%h t=%h expected 0123 002a", distance, texture);
        end
    endtask

    task automatic test_out_of_range();
        logic [15:0] keep_d;
        logic [15:0] keep_t;
        int idxs [3] = '{320, 327, 511};
        foreach (idxs[i]) begin
            gpu_read(idxs[i]);
            checks++;
            if (distance !== 16'hFFFF || texture !== 16'h0000) begin
                errors++;
                $display("FAIL oor_gpu idx=%0d got d=%h t=%h expected ffff 0000", idxs[i], distance, texture);
            end
        end
        keep_d = m_dist[1-m_front][144];
        keep_t = m_tex[1-m_front][144];
        cpu_write(400, 1'b0, ~keep_d);
        cpu_write(400, 1'b1, ~keep_t);
        cpu_read(144, 1'b0);
        checks++;
        if (cpu_rdata !== keep_d) begin
            errors++;
            $display("FAIL oor_alias_dist got %h expected %h", cpu_rdata, keep_d);
        end
        cpu_read(144, 1'b1);
        checks++;
        if (cpu_rdata !== keep_t) begin
            errors++;
            $display("FAIL oor_alias_tex got %h expected %h", cpu_rdata, keep_t);
        end
        cpu_read(400, 1'b0);
        checks++;
        if (cpu_rdata !== 16'h0000) begin
            errors++;
            $display("FAIL oor_cpu_read got %h expected 0000", cpu_rdata);
        end
    endtask

    task automatic test_double_request();
        int pulses;
        cpu_write(5, 1'b0, 16'h0123);
        request_swap();
        request_swap();
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL double_pending got %b expected 1", swap_pending);
        end
        vsync_fall(pulses);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL double_req got pulses=%0d expected 1", pulses);
        end
        vsync_fall(pulses);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_fall got pulses=%0d expected 0", pulses);
        end
        gpu_read(5);
        checks++;
        if (distance !== 16'h0123 || distance !== exp_dist(5)) begin
            errors++;
            $display("FAIL idle_fall_col5 got %h expected 0123", distance);
        end
        // Request coinciding with a v_sync fall is accepted but waits a frame.
        swap_req = 1'b1;
        v_sync   = 1'b0;
        step();
        swap_req = 1'b0;
        m_pending = 1'b1;
        checks++;
        if (swap_pending !== 1'b1 || frame_swapped !== 1'b0) begin
            errors++;
            $display("FAIL req_on_fall got pend=%b fs=%b expected 1 0", swap_pending, frame_swapped);
        end
        step(); step();
        v_sync = 1'b1;
        step(); step();
        vsync_fall(pulses);
        checks++;
        if (pulses != 1) begin
            errors++;
            $display("FAIL req_on_fall_next got pulses=%0d expected 1", pulses);
        end
    endtask

    task automatic test_swap_cycle_write();
        logic [15:0] base;
        logic [15:0] last;
        bit          seen;
        base = 16'($urandom);
        last = base;
        seen = 1'b0;
        request_swap();
        v_sync        = 1'b0;
        reading_index = 9'd7;
        cpu_addr      = {9'd7, 1'b0};
        cpu_we        = 1'b1;
        for (int i = 0; i < 4 && !seen; i++) begin
            logic [15:0] old_front;
            old_front = m_dist[m_front][7];
            last      = base + 16'(i);
            cpu_wdata = last;
            step();
            m_dist[1-m_front][7] = last;
            checks++;
            if (distance !== old_front) begin
                errors++;
                $display("FAIL swap_cycle_gpu cyc=%0d got %h expected %h", i, distance, old_front);
            end
            if (frame_swapped === 1'b1) begin
                seen      = 1'b1;
                m_front   = 1 - m_front;
                m_pending = 1'b0;
            end
        end
        cpu_we = 1'b0;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL swap_cycle_timeout got no frame_swapped expected a pulse");
        end
        step();
        checks++;
        if (distance !== last || distance !== exp_dist(7)) begin
            errors++;
            $display("FAIL swap_cycle_write got %h expected %h", distance, last);
        end
        v_sync = 1'b1;
        step(); step();
    endtask

    task automatic test_mid_reset();
        int pulses;
        request_swap();
        checks++;
        if (swap_pending !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_pre got pend=%b expected 1", swap_pending);
        end
        clr = 1'b1;
        #2;
        checks++;
        if (swap_pending !== 1'b0 || frame_swapped !== 1'b0 ||
            distance !== 16'h0 || texture !== 16'h0 || cpu_rdata !== 16'h0) begin
            errors++;
            $display("FAIL mid_reset got pend=%b fs=%b d=%h t=%h r=%h expected all 0",
                     swap_pending, frame_swapped, distance, texture, cpu_rdata);
        end
        step();
        clr       = 1'b0;
        m_front   = 0;
        m_pending = 1'b0;
        vsync_fall(pulses);
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL mid_reset_fall got pulses=%0d expected 0", pulses);
        end
        for (int i = 0; i < 8; i++) begin
            int idx;
            idx = int'($urandom_range(NCOL - 1, 0));
            gpu_read(idx);
            checks++;
            if (distance !== exp_dist(idx) || texture !== exp_tex(idx)) begin
                errors++;
                $display("FAIL mid_reset_bank0 idx=%0d got d=%h t=%h expected d=%h t=%h",
                         idx, distance, texture, exp_dist(idx), exp_tex(idx));
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill_and_read();
        test_basic_swap();
        test_out_of_range();
        test_double_request();
        test_swap_cycle_write();
        test_mid_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
